// File: rtl/ahb_lite_slave_regfile.sv
// AHB-lite register-file slave: NUM_REGS x 32-bit read/write registers,
// WAIT_STATES wait cycles on every OKAY data phase, two-cycle ERROR response.
// Ports: HCLK/HRESETn clock and async active-low reset; HSEL/HADDR/HTRANS/
//        HWRITE/HSIZE/HWDATA/HREADY from the bus and the response mux;
//        HRDATA_S/HREADYOUT/HRESP_S back to the response mux.
module ahb_lite_slave_regfile #(
  parameter int NUM_REGS    = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA_S,
  output logic        HREADYOUT,
  output logic        HRESP_S
);

  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t        state, state_n;
  logic [3:0]    cnt, cnt_n;
  logic [31:0]   regs [NUM_REGS];

  // Fields of the transfer currently in its data phase
  logic [IW-1:0] cap_idx;
  logic [3:0]    cap_be;
  logic          cap_write;

  logic [7:0]    req_idx;
  logic [3:0]    req_be;
  logic          req_err;
  logic          accept;
  logic          capture;
  logic          unused_bits;

  assign unused_bits = ^{HADDR[31:10], HTRANS[0]};
  assign req_idx     = HADDR[9:2];

  // A new address phase can only be taken in a cycle where this slave is
  // presenting HREADYOUT=1 (idle, last data cycle, or second ERROR cycle).
  assign accept  = (state == S_IDLE) || (state == S_DATA) || (state == S_ERR2);
  assign capture = accept && HSEL && HREADY && HTRANS[1];

  // Address-phase decode: byte lanes (little-endian) and error detection
  always_comb begin
    req_err = 1'b0;
    req_be  = 4'b0000;
    if ({24'd0, req_idx} >= NUM_REGS) req_err = 1'b1;
    case (HSIZE)
      3'b000: req_be = 4'b0001 << HADDR[1:0];
      3'b001: begin
        req_be = HADDR[1] ? 4'b1100 : 4'b0011;
        if (HADDR[0]) req_err = 1'b1;
      end
      3'b010: begin
        req_be = 4'b1111;
        if (HADDR[1:0] != 2'b00) req_err = 1'b1;
      end
      default: req_err = 1'b1;
    endcase
  end

  // Next state and bus response
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    HREADYOUT = 1'b1;
    HRESP_S   = 1'b0;
    HRDATA_S  = 32'h0;
    case (state)
      S_WAIT: begin
        HREADYOUT = 1'b0;
        if (cnt == 4'd0) state_n = S_DATA;
        else             cnt_n   = cnt - 4'd1;
      end
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP_S   = 1'b1;
        state_n   = S_ERR2;
      end
      default: begin
        if (state == S_ERR2) HRESP_S = 1'b1;
        // Read data is combinational from the array, so a write committed
        // at the previous edge is already visible here.
        if (state == S_DATA && !cap_write) HRDATA_S = regs[cap_idx];
        if (capture) begin
          if (req_err) begin
            state_n = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_n = S_WAIT;
            cnt_n   = WS_LOAD;
          end else begin
            state_n = S_DATA;
          end
        end else begin
          state_n = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      cap_idx   <= '0;
      cap_be    <= 4'b0000;
      cap_write <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (capture) begin
        cap_idx   <= HADDR[2 +: IW];
        cap_be    <= req_be;
        cap_write <= HWRITE;
      end
    end
  end

  // Register array; writes land at the closing edge of the DATA cycle only,
  // so errored or abandoned transfers never touch it.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 32'h0;
    end else if (state == S_DATA && cap_write) begin
      for (int b = 0; b < 4; b++) begin
        if (cap_be[b]) regs[cap_idx][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_slave_regfile.sv
module tb_ahb_lite_slave_regfile;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Shared bus drive; cur picks which DUT is selected and observed
  logic        bus_sel = 1'b0;
  logic [31:0] haddr = 32'h0;
  logic [31:0] hwdata = 32'h0;
  logic [1:0]  htrans = 2'b00;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'b000;
  logic        stall = 1'b0;
  int          cur = 0;

  logic [31:0] rdata0, rdata1, rd_cur;
  logic        ro0, ro1, resp0, resp1, ro_cur, resp_cur;
  logic        hsel0, hsel1, hready0, hready1;

  assign hsel0    = bus_sel && (cur == 0);
  assign hsel1    = bus_sel && (cur == 1);
  assign hready0  = ro0 & ~stall;
  assign hready1  = ro1 & ~stall;
  assign rd_cur   = (cur == 1) ? rdata1 : rdata0;
  assign ro_cur   = (cur == 1) ? ro1 : ro0;
  assign resp_cur = (cur == 1) ? resp1 : resp0;

  ahb_lite_slave_regfile #(.NUM_REGS(16), .WAIT_STATES(0)) dut0 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready0),
    .HRDATA_S(rdata0), .HREADYOUT(ro0), .HRESP_S(resp0)
  );

  ahb_lite_slave_regfile #(.NUM_REGS(16), .WAIT_STATES(3)) dut1 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel1), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready1),
    .HRDATA_S(rdata1), .HREADYOUT(ro1), .HRESP_S(resp1)
  );

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [1:0]  trans;
    logic        sel;
    logic        cap;
  } cmd_t;

  typedef struct {
    logic        err;
    logic        wr;
    logic [31:0] rdata;
  } exp_t;

  cmd_t        cmdq[$];
  exp_t        sbq[$];
  cmd_t        ap;
  logic        ap_valid = 1'b0;
  logic        dp_valid = 1'b0;
  int          wcnt = 0;
  int          ecnt = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mdl [2][16];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++)
      for (int r = 0; r < 16; r++) mdl[d][r] = 32'h0;
  endtask

  // Queue a transfer; the expected response is derived here, in issue order
  task automatic push(input logic [31:0] a, input logic wr, input logic [2:0] sz,
                      input logic [31:0] wd, input logic [1:0] tr, input logic sel);
    cmd_t c;
    exp_t e;
    int   idx;
    logic hit;
    c.addr = a; c.wr = wr; c.size = sz; c.wdata = wd; c.trans = tr; c.sel = sel;
    c.cap = sel & tr[1];
    if (c.cap) begin
      idx     = int'(a[9:2]);
      e.err   = (idx >= 16) || (sz > 3'd2) || (sz == 3'd1 && a[0]) ||
                (sz == 3'd2 && a[1:0] != 2'b00);
      e.wr    = wr;
      e.rdata = 32'h0;
      if (!e.err) begin
        if (!wr) begin
          e.rdata = mdl[cur][idx];
        end else begin
          for (int b = 0; b < 4; b++) begin
            hit = (sz == 3'd0) ? (b == int'(a[1:0])) :
                  (sz == 3'd1) ? ((b >> 1) == int'(a[1])) : 1'b1;
            if (hit) mdl[cur][idx][8*b +: 8] = wd[8*b +: 8];
          end
        end
      end
      sbq.push_back(e);
    end
    cmdq.push_back(c);
  endtask

  task automatic rw(input logic [31:0] a, input logic wr, input logic [2:0] sz, input logic [31:0] wd);
    push(a, wr, sz, wd, 2'b10, 1'b1);
  endtask

  // Mid-cycle observation of the selected DUT
  task automatic monitor();
    exp_t e;
    if (dp_valid) begin
      if (sbq.size() == 0) begin
        check("sb_underflow", 64'(sbq.size()), 64'd1);
        dp_valid = 1'b0;
      end else if (!ro_cur) begin
        e = sbq[0];
        if (e.err) begin
          check("err1_out", {resp_cur, rd_cur}, {1'b1, 32'h0});
          ecnt++;
        end else begin
          check("wait_out", {resp_cur, rd_cur}, {1'b0, 32'h0});
          wcnt++;
        end
      end else begin
        e = sbq.pop_front();
        if (e.err) begin
          check("err2_resp", resp_cur, 1);
          check("err_cycles", ecnt, 1);
          check("err_rdata", rd_cur, 0);
        end else begin
          check("okay_resp", resp_cur, 0);
          check("wait_cycles", wcnt, (cur == 1) ? 3 : 0);
          check(e.wr ? "wr_rdata" : "rd_data", rd_cur, e.rdata);
        end
        ecnt = 0;
        wcnt = 0;
        dp_valid = 1'b0;
      end
    end else begin
      check("idle_out", {ro_cur, resp_cur, rd_cur}, {1'b1, 1'b0, 32'h0});
    end
  endtask

  // Pipelined master: advance phases when the previous edge saw HREADY high
  task automatic step(input logic hr);
    if (hr) begin
      if (ap_valid) begin
        dp_valid = ap.cap;
        hwdata   = ap.wdata;
      end else begin
        hwdata   = 32'h0;
      end
      if (cmdq.size() > 0) begin
        ap = cmdq.pop_front();
        ap_valid = 1'b1;
        bus_sel = ap.sel; haddr = ap.addr; htrans = ap.trans;
        hwrite = ap.wr; hsize = ap.size;
      end else begin
        ap_valid = 1'b0;
        bus_sel = 1'b0; haddr = 32'h0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'b000;
      end
    end
  endtask

  task automatic run(input int maxc);
    int   c;
    logic hr;
    c = 0;
    while ((cmdq.size() != 0 || ap_valid || dp_valid) && c < maxc) begin
      @(negedge clk);
      monitor();
      hr = (cur == 1) ? hready1 : hready0;
      @(posedge clk);
      #1;
      step(hr);
      c++;
    end
    check("drain", 64'(cmdq.size()) + 64'(ap_valid) + 64'(dp_valid), 64'd0);
  endtask

  initial begin
    clear_model();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out0", {ro0, resp0, rdata0}, {1'b1, 1'b0, 32'h0});
    check("reset_out1", {ro1, resp1, rdata1}, {1'b1, 1'b0, 32'h0});
    @(posedge clk); #1 rst_n = 1'b1;

    // Zero-wait slave: all registers read back zero after reset
    cur = 0;
    for (int i = 0; i < 16; i++) rw(32'(i * 4), 1'b0, 3'd2, 32'h0);
    run(200);

    // Word then byte-lane merge, halfword upper lanes
    rw(32'h08, 1'b1, 3'd2, 32'hDEADBEEF);
    rw(32'h09, 1'b1, 3'd0, 32'h0000AA00);
    rw(32'h08, 1'b0, 3'd2, 32'h0);
    rw(32'h06, 1'b1, 3'd1, 32'hBEEF1234);
    rw(32'h04, 1'b0, 3'd2, 32'h0);
    rw(32'h03, 1'b1, 3'd0, 32'h77000000);
    rw(32'h00, 1'b0, 3'd0, 32'h0);
    run(100);

    // Back-to-back write/read, then BUSY and unselected cycles change nothing
    rw(32'h0C, 1'b1, 3'd2, 32'h12345678);
    rw(32'h0C, 1'b0, 3'd2, 32'h0);
    push(32'h0C, 1'b1, 3'd2, 32'hFFFFFFFF, 2'b01, 1'b1);
    push(32'h0C, 1'b1, 3'd2, 32'hFFFFFFFF, 2'b10, 1'b0);
    rw(32'h0C, 1'b0, 3'd2, 32'h0);
    run(100);

    // Error transfers: out of range, misaligned, illegal size
    rw(32'h40, 1'b0, 3'd2, 32'h0);
    rw(32'h42, 1'b1, 3'd1, 32'hFFFF0000);
    rw(32'h09, 1'b1, 3'd1, 32'h11111111);
    rw(32'h0A, 1'b1, 3'd2, 32'h22222222);
    rw(32'h08, 1'b1, 3'd3, 32'h33333333);
    rw(32'h08, 1'b0, 3'd2, 32'h0);
    rw(32'h3FC, 1'b0, 3'd2, 32'h0);
    rw(32'h3C, 1'b0, 3'd2, 32'h0);
    run(100);

    // Another slave stalling HREADY must not trigger a capture
    stall = 1'b1;
    @(posedge clk); #1;
    bus_sel = 1'b1; haddr = 32'h08; htrans = 2'b10; hwrite = 1'b0; hsize = 3'd2;
    repeat (2) begin
      @(negedge clk);
      check("stall_out", {ro0, resp0, rdata0}, {1'b1, 1'b0, 32'h0});
    end
    @(posedge clk); #1;
    stall = 1'b0; bus_sel = 1'b0; htrans = 2'b00;
    rw(32'h08, 1'b0, 3'd2, 32'h0);
    run(50);

    // Three-wait-state slave
    cur = 1;
    rw(32'h04, 1'b0, 3'd2, 32'h0);
    rw(32'h04, 1'b1, 3'd2, 32'hA5A5A5A5);
    rw(32'h04, 1'b0, 3'd2, 32'h0);
    rw(32'h14, 1'b1, 3'd2, 32'h5A5A5A5A);
    rw(32'h40, 1'b0, 3'd2, 32'h0);
    rw(32'h16, 1'b1, 3'd0, 32'h00C30000);
    rw(32'h14, 1'b0, 3'd2, 32'h0);
    run(200);

    // Reset while a write sits in its wait states
    @(posedge clk); #1;
    bus_sel = 1'b1; haddr = 32'h14; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
    @(posedge clk); #1;
    bus_sel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = 32'hCAFEF00D;
    @(negedge clk);
    check("pre_rst_wait", ro1, 0);
    rst_n = 1'b0;
    #1;
    check("rst_out", {ro1, resp1, rdata1}, {1'b1, 1'b0, 32'h0});
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    hwdata = 32'h0;
    clear_model();
    sbq.delete();
    cmdq.delete();
    ap_valid = 1'b0;
    dp_valid = 1'b0;
    wcnt = 0;
    ecnt = 0;
    rw(32'h14, 1'b0, 3'd2, 32'h0);
    rw(32'h04, 1'b0, 3'd2, 32'h0);
    run(100);
    cur = 0;
    rw(32'h08, 1'b0, 3'd2, 32'h0);
    rw(32'h0C, 1'b0, 3'd2, 32'h0);
    run(50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
